fmi_tile_loader: RTL and testbench
==================================

FMI_TILE_LOADER -- requirements
Module: fmi_tile_loader

Interface
REQ-001 Parameter PX_W, default 16, pixel width in bits.
REQ-002 Parameter FMI_N_ELEM, default 4096, capacity of the FM-input tile RAM in pixels.
REQ-003 Parameter DIM_W, default 8, width of the row, column and channel count fields.
REQ-004 Port clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port start  input  1  one-cycle request to load a tile; sampled only in IDLE.
REQ-007 Port n_rows, n_cols, n_ch  input  DIM_W each  unpadded tile dimensions; 0 is illegal.
REQ-008 Port pad_t, pad_b, pad_l, pad_r  input  1 each  insert one zero row or column on that edge.
REQ-009 Port in_data  input  PX_W  incoming pixel.
REQ-010 Port in_valid  input  1  in_data is valid.
REQ-011 Port in_ready  output  1  loader accepts in_data this cycle.
REQ-012 Port wr_addr  output  $clog2(FMI_N_ELEM)  RAM write address.
REQ-013 Port wr_data  output  PX_W  RAM write data.
REQ-014 Port wr_en  output  1  RAM write strobe.
REQ-015 Port busy  output  1  high in LOAD.
REQ-016 Port done  output  1  one-cycle pulse when the last pixel has been written.
REQ-017 Port err  output  1  one-cycle pulse when start is rejected.

Function
REQ-018 The FSM SHALL have three states: IDLE, LOAD and FLUSH.
REQ-019 IDLE + start SHALL latch all dimension and pad inputs and compute R=n_rows+pad_t+pad_b, C=n_cols+pad_l+pad_r, and N=R*C*n_ch at full width with no truncation.
REQ-020 If N > FMI_N_ELEM, or if any of n_rows, n_cols or n_ch is 0, the loader SHALL pulse err the next cycle and stay in IDLE; otherwise it SHALL enter LOAD.
REQ-021 Traversal order SHALL be channel fastest, then padded column, then padded row; one position is visited per cycle in which it advances.
REQ-022 The position is a pad position if row==0 with pad_t, row==R-1 with pad_b, col==0 with pad_l, or col==C-1 with pad_r.
REQ-023 At a pad position the loader SHALL drive in_ready=0, write zero and advance unconditionally.
REQ-024 At a data position in_ready SHALL be 1; the loader SHALL write in_data and advance only when in_valid=1, and otherwise hold position with no write.
REQ-025 wr_en, wr_addr and wr_data SHALL be registered, with wr_en asserted exactly one cycle after the position advances.
REQ-026 wr_addr SHALL be a linear counter starting at 0 and incrementing by 1 per write, ending at N-1.
REQ-027 After the position at address N-1 advances, the FSM SHALL move to FLUSH; in_ready SHALL be 0 in FLUSH.
REQ-028 FLUSH SHALL last one cycle, during which the final write is issued and done pulses, then return to IDLE.
REQ-029 done and the final wr_en SHALL coincide.
REQ-030 start SHALL be ignored in LOAD and FLUSH.
REQ-031 in_ready SHALL be 0 in IDLE and FLUSH.
REQ-032 busy SHALL be 1 in LOAD and FLUSH.
REQ-033 A tile of exactly FMI_N_ELEM pixels SHALL be accepted, with the last address FMI_N_ELEM-1 and no wrap-around.

Reset
REQ-034 reset SHALL return the FSM to IDLE and clear all counters; it takes priority over every other input.
REQ-035 The outputs in_ready, wr_en, busy, done and err SHALL be 0, and wr_addr and wr_data SHALL be 0, in the cycle after reset is sampled.
REQ-036 A reset asserted mid-LOAD SHALL abort the load with no further writes and no done pulse.

Verification
REQ-037 The bench SHALL cover: n_rows=2, n_cols=2, n_ch=1, no pad, stream 1,2,3,4 with in_valid always high -> writes (0,1), (1,2), (2,3), (3,4) on consecutive cycles, with done on the write to address 3.
REQ-038 The bench SHALL cover: n_rows=1, n_cols=1, n_ch=2, all four pads, stream 7,8 -> 18 writes in total, addresses 8 and 9 hold 7 and 8, every other address holds 0, and in_ready is high only on those two positions.
REQ-039 The bench SHALL cover: the same 2x2x1 case with in_valid low on alternate cycles -> the written data is identical, wr_en has gaps matching the stall cycles, and wr_addr has no skips.
REQ-040 The bench SHALL cover: FMI_N_ELEM=4096, n_rows=64, n_cols=64, n_ch=2 -> err pulse, no writes, busy stays 0; then n_ch=1 -> 4096 writes with last address 4095, then done.
REQ-041 The bench SHALL cover: reset asserted after 3 writes of a 16-pixel tile -> no further wr_en, no done, in_ready=0; a new start then begins again at address 0.
REQ-042 The bench SHALL cover: start held high through LOAD and FLUSH -> exactly one load is performed; a start given on the cycle after done begins a new load.

Source files
------------

// File: rtl/fmi_tile_loader.sv
// FM-input tile loader: streams one tile into the tile RAM, inserting a zero
// row/column on each selected edge. The RAM write port is fully registered.
//   state | meaning
//   IDLE  | waiting for start; checks the requested tile against RAM capacity
//   LOAD  | walking padded positions (channel, then column, then row)
//   FLUSH | final write and done pulse are on the RAM port
module fmi_tile_loader #(
    parameter int PX_W       = 16,
    parameter int FMI_N_ELEM = 4096,
    parameter int DIM_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [DIM_W-1:0]              n_rows,
    input  logic [DIM_W-1:0]              n_cols,
    input  logic [DIM_W-1:0]              n_ch,
    input  logic                          pad_t,
    input  logic                          pad_b,
    input  logic                          pad_l,
    input  logic                          pad_r,
    input  logic [PX_W-1:0]               in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [$clog2(FMI_N_ELEM)-1:0] wr_addr,
    output logic [PX_W-1:0]               wr_data,
    output logic                          wr_en,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    localparam int AW = $clog2(FMI_N_ELEM);
    localparam int PW = DIM_W + 1;
    localparam int NW = 3 * PW;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;
    state_t state;

    logic [PW-1:0]    r_full;
    logic [PW-1:0]    c_full;
    logic [NW-1:0]    n_full;
    logic             bad_req;

    logic             pad_t_q, pad_b_q, pad_l_q, pad_r_q;
    logic [PW-1:0]    row_last, col_last;
    logic [DIM_W-1:0] ch_last;
    logic [AW-1:0]    addr_last;

    logic [PW-1:0]    row_cnt, col_cnt;
    logic [DIM_W-1:0] ch_cnt;
    logic [AW-1:0]    addr_cnt;

    logic             is_pad;
    logic             advance;

    // Full-width tile size so oversize requests can never alias into range.
    assign r_full  = PW'(n_rows) + PW'(pad_t) + PW'(pad_b);
    assign c_full  = PW'(n_cols) + PW'(pad_l) + PW'(pad_r);
    assign n_full  = NW'(r_full) * NW'(c_full) * NW'(n_ch);
    assign bad_req = (n_rows == '0) || (n_cols == '0) || (n_ch == '0)
                   || (64'(n_full) > 64'(FMI_N_ELEM));

    assign is_pad = (pad_t_q && (row_cnt == '0))
                 || (pad_b_q && (row_cnt == row_last))
                 || (pad_l_q && (col_cnt == '0))
                 || (pad_r_q && (col_cnt == col_last));

    assign advance  = (state == LOAD) && (is_pad || in_valid);
    assign in_ready = (state == LOAD) && !is_pad;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pad_t_q   <= 1'b0;
            pad_b_q   <= 1'b0;
            pad_l_q   <= 1'b0;
            pad_r_q   <= 1'b0;
            row_last  <= '0;
            col_last  <= '0;
            ch_last   <= '0;
            addr_last <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            ch_cnt    <= '0;
            addr_cnt  <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pad_t_q   <= pad_t;
                        pad_b_q   <= pad_b;
                        pad_l_q   <= pad_l;
                        pad_r_q   <= pad_r;
                        row_last  <= r_full - PW'(1);
                        col_last  <= c_full - PW'(1);
                        ch_last   <= n_ch - DIM_W'(1);
                        addr_last <= AW'(n_full - NW'(1));
                        row_cnt   <= '0;
                        col_cnt   <= '0;
                        ch_cnt    <= '0;
                        addr_cnt  <= '0;
                        if (bad_req) begin
                            err <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (advance) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= addr_cnt;
                        wr_data  <= is_pad ? '0 : in_data;
                        addr_cnt <= addr_cnt + AW'(1);
                        if (ch_cnt == ch_last) begin
                            ch_cnt <= '0;
                            if (col_cnt == col_last) begin
                                col_cnt <= '0;
                                row_cnt <= row_cnt + PW'(1);
                            end else begin
                                col_cnt <= col_cnt + PW'(1);
                            end
                        end else begin
                            ch_cnt <= ch_cnt + DIM_W'(1);
                        end
                        // done is registered alongside the last write so both land in FLUSH.
                        if (addr_cnt == addr_last) begin
                            done  <= 1'b1;
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fmi_tile_loader.sv
// Scoreboard bench for fmi_tile_loader: a tile model queues expected RAM writes,
// a monitor pops and compares them as wr_en appears.
module tb_fmi_tile_loader;
    localparam int PX_W       = 16;
    localparam int FMI_N_ELEM = 4096;
    localparam int DIM_W      = 8;
    localparam int AW         = $clog2(FMI_N_ELEM);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [DIM_W-1:0] n_rows = '0, n_cols = '0, n_ch = '0;
    logic             pad_t = 1'b0, pad_b = 1'b0, pad_l = 1'b0, pad_r = 1'b0;
    logic [PX_W-1:0]  in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [AW-1:0]    wr_addr;
    logic [PX_W-1:0]  wr_data;
    logic             wr_en, busy, done, err;

    fmi_tile_loader #(.PX_W(PX_W), .FMI_N_ELEM(FMI_N_ELEM), .DIM_W(DIM_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .n_rows(n_rows), .n_cols(n_cols), .n_ch(n_ch),
        .pad_t(pad_t), .pad_b(pad_b), .pad_l(pad_l), .pad_r(pad_r),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        bit last;
    } wr_t;

    wr_t             exp_q[$];
    logic [PX_W-1:0] pix_q[$];
    int checks = 0, failures = 0;
    int wr_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, rdy_cnt = 0, gap_cnt = 0;
    int last_done_addr = -1;
    bit in_span = 1'b0;
    int drv_mode = 0;
    bit alt = 1'b1;
    bit hs_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) rdy_cnt++;
            if (busy === 1'b1) busy_cnt++;
            if (err === 1'b1) err_cnt++;
            if (in_span && wr_en !== 1'b1) gap_cnt++;
            if (wr_en === 1'b1) begin
                wr_cnt++;
                in_span = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%0d data=%0h required=no_write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                    chk("wr_data", 32'(wr_data), 32'(e.data));
                    chk("done_on_write", 32'(done), 32'(e.last));
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    in_span = 1'b0;
                    last_done_addr = int'(wr_addr);
                end
            end else if (done === 1'b1) begin
                checks++;
                failures++;
                done_cnt++;
                $display("FAIL done_without_write done=1 required wr_en=1");
            end
        end
    endtask

    // Presents queued pixels; mode 0 always valid, 1 alternating, 2 random.
    task automatic driver();
        bit v;
        forever begin
            @(negedge clk);
            if (hs_pend && pix_q.size() > 0) void'(pix_q.pop_front());
            hs_pend = 1'b0;
            if (pix_q.size() > 0) begin
                case (drv_mode)
                    0:       v = 1'b1;
                    1:       v = alt;
                    default: v = ($urandom_range(0, 2) != 0);
                endcase
                if (drv_mode == 1 && in_ready === 1'b1) alt = !alt;
                in_valid = v;
                in_data  = pix_q[0];
                hs_pend  = v && (in_ready === 1'b1);
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
        end
    endtask

    // Reference: walk padded positions row, column, channel; pads write zero.
    task automatic build_tile(input int rows, input int cols, input int ch,
                              input bit pt, input bit pb, input bit pl, input bit pr,
                              input int base);
        int R = rows + int'(pt) + int'(pb);
        int C = cols + int'(pl) + int'(pr);
        int n = R * C * ch;
        int a = 0;
        int k = 0;
        bit pad;
        wr_t e;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                for (int h = 0; h < ch; h++) begin
                    pad = (pt && r == 0) || (pb && r == R - 1) || (pl && c == 0) || (pr && c == C - 1);
                    e.addr = a;
                    if (pad) e.data = 0;
                    else if (base >= 0) e.data = base + k;
                    else e.data = int'($urandom_range(0, 65535));
                    if (!pad) begin
                        pix_q.push_back(PX_W'(e.data));
                        k++;
                    end
                    e.last = (a == n - 1);
                    exp_q.push_back(e);
                    a++;
                end
    endtask

    task automatic set_dims(input int rows, input int cols, input int ch,
                            input bit pt, input bit pb, input bit pl, input bit pr);
        n_rows = DIM_W'(rows);
        n_cols = DIM_W'(cols);
        n_ch   = DIM_W'(ch);
        pad_t = pt; pad_b = pb; pad_l = pl; pad_r = pr;
    endtask

    task automatic apply_start(input int rows, input int cols, input int ch,
                               input bit pt, input bit pb, input bit pl, input bit pr);
        @(negedge clk);
        set_dims(rows, cols, ch, pt, pb, pl, pr);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL %s_timeout done_seen=0 required=1 within %0d cycles", name, budget);
        end
    endtask

    int w0, d0, e0, b0, r0, g0, n;

    initial begin
        fork
            monitor();
            driver();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        @(negedge clk);
        reset = 1'b0;

        // 2x2x1 stream 1..4, valid always high
        drv_mode = 0;
        w0 = wr_cnt; d0 = done_cnt; g0 = gap_cnt;
        build_tile(2, 2, 1, 0, 0, 0, 0, 1);
        apply_start(2, 2, 1, 0, 0, 0, 0);
        wait_done("basic", d0, 50);
        chk("basic_writes", 32'(wr_cnt - w0), 4);
        chk("basic_gaps", 32'(gap_cnt - g0), 0);
        chk("basic_last_addr", 32'(last_done_addr), 3);

        // 1x1x2 with all four pads, stream 7,8
        w0 = wr_cnt; d0 = done_cnt; r0 = rdy_cnt;
        build_tile(1, 1, 2, 1, 1, 1, 1, 7);
        apply_start(1, 1, 2, 1, 1, 1, 1);
        wait_done("allpad", d0, 100);
        chk("allpad_writes", 32'(wr_cnt - w0), 18);
        chk("allpad_ready_cycles", 32'(rdy_cnt - r0), 2);
        chk("allpad_last_addr", 32'(last_done_addr), 17);

        // 2x2x1 with in_valid alternating
        drv_mode = 1; alt = 1'b1;
        w0 = wr_cnt; d0 = done_cnt; g0 = gap_cnt;
        build_tile(2, 2, 1, 0, 0, 0, 0, 1);
        apply_start(2, 2, 1, 0, 0, 0, 0);
        wait_done("stall", d0, 50);
        chk("stall_writes", 32'(wr_cnt - w0), 4);
        chk("stall_gaps", 32'(gap_cnt - g0), 3);

        // Oversize and zero-dimension requests are rejected
        drv_mode = 2;
        w0 = wr_cnt; e0 = err_cnt; b0 = busy_cnt;
        apply_start(64, 64, 2, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        #2;
        chk("oversize_err", 32'(err_cnt - e0), 1);
        chk("oversize_busy", 32'(busy_cnt - b0), 0);
        chk("oversize_writes", 32'(wr_cnt - w0), 0);
        e0 = err_cnt;
        apply_start(3, 0, 1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #2;
        chk("zero_dim_err", 32'(err_cnt - e0), 1);
        chk("zero_dim_writes", 32'(wr_cnt - w0), 0);

        // Exactly-full tile
        d0 = done_cnt; e0 = err_cnt;
        build_tile(64, 64, 1, 0, 0, 0, 0, -1);
        apply_start(64, 64, 1, 0, 0, 0, 0);
        wait_done("full", d0, 20000);
        chk("full_writes", 32'(wr_cnt - w0), 4096);
        chk("full_last_addr", 32'(last_done_addr), 4095);
        chk("full_no_err", 32'(err_cnt - e0), 0);

        // Reset after three writes of a 4x4x1 tile
        drv_mode = 0;
        w0 = wr_cnt; d0 = done_cnt;
        build_tile(4, 4, 1, 0, 0, 0, 0, -1);
        apply_start(4, 4, 1, 0, 0, 0, 0);
        n = 0;
        while ((wr_cnt - w0) < 3 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_reached_3_writes", 32'(wr_cnt - w0), 3);
        reset = 1'b1;
        exp_q.delete();
        pix_q.delete();
        hs_pend = 1'b0;
        w0 = wr_cnt; r0 = rdy_cnt;
        @(negedge clk);
        #2;
        chk("abort_wr_en", 32'(wr_en), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_wr_addr", 32'(wr_addr), 0);
        chk("abort_wr_data", 32'(wr_data), 0);
        @(negedge clk);
        reset = 1'b0;
        in_span = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        chk("abort_no_more_writes", 32'(wr_cnt - w0), 0);
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        chk("abort_no_ready", 32'(rdy_cnt - r0), 0);
        d0 = done_cnt; w0 = wr_cnt;
        build_tile(2, 2, 1, 0, 0, 0, 0, -1);
        apply_start(2, 2, 1, 0, 0, 0, 0);
        wait_done("restart", d0, 50);
        chk("restart_writes", 32'(wr_cnt - w0), 4);

        // start held through LOAD and FLUSH, then a new start right after done
        drv_mode = 2;
        w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        build_tile(2, 3, 2, 0, 0, 0, 0, -1);
        @(negedge clk);
        set_dims(2, 3, 2, 0, 0, 0, 0);
        start = 1'b1;
        wait_done("held_start", d0, 200);
        start = 1'b0;
        @(negedge clk);
        #2;
        chk("held_one_load_writes", 32'(wr_cnt - w0), 12);
        chk("held_idle_after_done", 32'(busy), 0);
        build_tile(3, 1, 1, 0, 0, 0, 0, -1);
        set_dims(3, 1, 1, 0, 0, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("back_to_back", d0 + 1, 100);
        chk("b2b_writes", 32'(wr_cnt - w0), 15);
        chk("b2b_last_addr", 32'(last_done_addr), 2);
        chk("b2b_no_err", 32'(err_cnt - e0), 0);

        // Random small tiles with random pads and random valid
        for (int t = 0; t < 4; t++) begin
            int rr, cc, hh;
            bit a, b, c, d;
            rr = int'($urandom_range(1, 6));
            cc = int'($urandom_range(1, 6));
            hh = int'($urandom_range(1, 3));
            a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1));
            d0 = done_cnt; w0 = wr_cnt;
            build_tile(rr, cc, hh, a, b, c, d, -1);
            apply_start(rr, cc, hh, a, b, c, d);
            wait_done("random", d0, 2000);
            chk("random_writes", 32'(wr_cnt - w0),
                32'((rr + int'(a) + int'(b)) * (cc + int'(c) + int'(d)) * hh));
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
